// File: rtl/shifter_ctrl.sv
// Control front-end for the ping-pong pitch shifter: button sync/debounce, sample
// strobe forwarding, frame tracking and frame-aligned mode commit. Macro SHIFTER_CTRL_LATCH_EN selects latching buttons.
module shifter_ctrl #(
    parameter int RAM_SIZE        = 1024,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_sample_valid,
    output logic       o_valid,
    output logic       o_up,
    output logic       o_down,
    output logic [1:0] o_mode,
    output logic       o_frame_start
);

    localparam int FRAME_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(RAM_SIZE - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10
    } mode_e;

    // Same priority as the shifter: exactly one button selects a direction.
    function automatic mode_e decode_req(input logic up, input logic down);
        mode_e m;
        case ({up, down})
            2'b10:   m = MODE_UP;
            2'b01:   m = MODE_DOWN;
            default: m = MODE_NORMAL;
        endcase
        return m;
    endfunction

    logic              btn_up_meta_r;
    logic              btn_up_sync_r;
    logic              btn_down_meta_r;
    logic              btn_down_sync_r;
    logic [DB_W-1:0]   up_cnt_r;
    logic [DB_W-1:0]   down_cnt_r;
    logic              up_deb_r;
    logic              down_deb_r;
    logic              up_diff_s;
    logic              down_diff_s;
    logic              up_commit_s;
    logic              down_commit_s;
    mode_e             req_s;
    mode_e             pend_r;
    mode_e             state_r;
    mode_e             state_next_s;
    logic              valid_r;
    logic [FRAME_W-1:0] frame_cnt_r;
    logic              boundary_s;
    logic              up_r;
    logic              down_r;
    logic [1:0]        mode_r;

    // Two-flop synchronisers for the asynchronous pushbuttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_up_meta_r   <= 1'b0;
            btn_up_sync_r   <= 1'b0;
            btn_down_meta_r <= 1'b0;
            btn_down_sync_r <= 1'b0;
        end else begin
            btn_up_meta_r   <= i_btn_up;
            btn_up_sync_r   <= btn_up_meta_r;
            btn_down_meta_r <= i_btn_down;
            btn_down_sync_r <= btn_down_meta_r;
        end
    end

    // A commit fires on the cycle the counter has already seen DEBOUNCE_CYCLES-1 differing cycles.
    always_comb begin
        up_diff_s     = btn_up_sync_r ^ up_deb_r;
        down_diff_s   = btn_down_sync_r ^ down_deb_r;
        up_commit_s   = up_diff_s && (up_cnt_r == DB_LAST);
        down_commit_s = down_diff_s && (down_cnt_r == DB_LAST);
    end

    // Up-button debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_cnt_r <= '0;
            up_deb_r <= 1'b0;
        end else if (up_commit_s) begin
            up_cnt_r <= '0;
            up_deb_r <= btn_up_sync_r;
        end else if (up_diff_s) begin
            up_cnt_r <= up_cnt_r + DB_ONE;
        end else begin
            up_cnt_r <= '0;
        end
    end

    // Down-button debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_cnt_r <= '0;
            down_deb_r <= 1'b0;
        end else if (down_commit_s) begin
            down_cnt_r <= '0;
            down_deb_r <= btn_down_sync_r;
        end else if (down_diff_s) begin
            down_cnt_r <= down_cnt_r + DB_ONE;
        end else begin
            down_cnt_r <= '0;
        end
    end

`ifdef SHIFTER_CTRL_LATCH_EN
    mode_e latch_r;
    mode_e latch_next_s;
    logic  up_rise_s;
    logic  down_rise_s;

    // A debounced rising edge is a commit towards level 1; simultaneous edges cancel.
    always_comb begin
        up_rise_s    = up_commit_s & btn_up_sync_r;
        down_rise_s  = down_commit_s & btn_down_sync_r;
        latch_next_s = latch_r;
        if (up_rise_s && down_rise_s) begin
            latch_next_s = latch_r;
        end else if (up_rise_s) begin
            latch_next_s = (latch_r == MODE_UP) ? MODE_NORMAL : MODE_UP;
        end else if (down_rise_s) begin
            latch_next_s = (latch_r == MODE_DOWN) ? MODE_NORMAL : MODE_DOWN;
        end else begin
            latch_next_s = latch_r;
        end
        req_s = latch_r;
    end

    // Latched request register, holds with buttons released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latch_r <= MODE_NORMAL;
        end else begin
            latch_r <= latch_next_s;
        end
    end
`else
    // Momentary request straight from the debounced levels.
    always_comb begin
        req_s = decode_req(up_deb_r, down_deb_r);
    end
`endif

    // Pending request tracks the latest request; the boundary sees last cycle's value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= MODE_NORMAL;
        end else begin
            pend_r <= req_s;
        end
    end

    // Sample strobe delay and frame position, aligned with the shifter write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            valid_r <= i_sample_valid;
            if (valid_r) begin
                frame_cnt_r <= frame_cnt_r + FRAME_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign boundary_s = valid_r && (frame_cnt_r == FRAME_LAST);

    // Mode FSM next state: only a frame boundary may move it.
    always_comb begin
        state_next_s = state_r;
        if (boundary_s) begin
            case (pend_r)
                MODE_NORMAL: state_next_s = MODE_NORMAL;
                MODE_UP:     state_next_s = MODE_UP;
                MODE_DOWN:   state_next_s = MODE_DOWN;
                default:     state_next_s = MODE_NORMAL;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Mode FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= MODE_NORMAL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output decode registered from the next state so it lands with the state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_r   <= 1'b0;
            down_r <= 1'b0;
            mode_r <= 2'b00;
        end else begin
            case (state_next_s)
                MODE_UP: begin
                    up_r   <= 1'b1;
                    down_r <= 1'b0;
                    mode_r <= 2'b01;
                end
                MODE_DOWN: begin
                    up_r   <= 1'b0;
                    down_r <= 1'b1;
                    mode_r <= 2'b10;
                end
                default: begin
                    up_r   <= 1'b0;
                    down_r <= 1'b0;
                    mode_r <= 2'b00;
                end
            endcase
        end
    end

    assign o_valid       = valid_r;
    assign o_up          = up_r;
    assign o_down        = down_r;
    assign o_mode        = mode_r;
    assign o_frame_start = valid_r && (frame_cnt_r == '0);

endmodule

// File: tb/tb_shifter_ctrl.sv
// Bench for shifter_ctrl (RAM_SIZE=8, DEBOUNCE_CYCLES=4): per-cycle model compare
// plus literal checkpoints along the directed scenarios.
module tb_shifter_ctrl;

    localparam int RAM = 8;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       sv = 1'b0;
    logic       o_valid;
    logic       o_up;
    logic       o_down;
    logic [1:0] o_mode;
    logic       o_frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int tot      = 0;

    always #5 clk = ~clk;

    shifter_ctrl #(.RAM_SIZE(RAM), .DEBOUNCE_CYCLES(DB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_up      (btn_up),
        .i_btn_down    (btn_down),
        .i_sample_valid(sv),
        .o_valid       (o_valid),
        .o_up          (o_up),
        .o_down        (o_down),
        .o_mode        (o_mode),
        .o_frame_start (o_frame_start)
    );

    // Model: a button level is accepted once the last DB synchronised samples
    // (pin seen two clocks earlier) all disagree with the accepted level.
    logic [DB:0] m_pin_up;
    logic [DB:0] m_pin_dn;
    logic        m_deb_up;
    logic        m_deb_dn;
    logic [1:0]  m_pend;
    logic [1:0]  m_mode;
    logic        m_ov;
    int          m_nval;

    function automatic logic [1:0] req_of(input logic u, input logic d);
        if (u && !d) return 2'b01;
        else if (d && !u) return 2'b10;
        else return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pin_up <= '0;
            m_pin_dn <= '0;
            m_deb_up <= 1'b0;
            m_deb_dn <= 1'b0;
            m_pend   <= 2'b00;
            m_mode   <= 2'b00;
            m_ov     <= 1'b0;
            m_nval   <= 0;
        end else begin
            m_pin_up <= {m_pin_up[DB-1:0], btn_up};
            m_pin_dn <= {m_pin_dn[DB-1:0], btn_down};
            if (m_pin_up[DB:1] == {DB{~m_deb_up}}) m_deb_up <= ~m_deb_up;
            if (m_pin_dn[DB:1] == {DB{~m_deb_dn}}) m_deb_dn <= ~m_deb_dn;
            m_pend <= req_of(m_deb_up, m_deb_dn);
            if (m_ov && (m_nval % RAM == RAM - 1)) m_mode <= m_pend;
            m_ov <= sv;
            if (m_ov) m_nval <= m_nval + 1;
        end
    end

    function automatic logic [7:0] outs();
        return {2'b00, o_valid, o_frame_start, o_up, o_down, o_mode};
    endfunction

    function automatic logic [7:0] model_outs();
        return {2'b00, m_ov, m_ov && (m_nval % RAM == 0),
                m_mode == 2'b01, m_mode == 2'b10, m_mode};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cycle_outputs", outs(), model_outs());
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the negedge where the registered o_valid for this sample is visible.
    task automatic send_one();
        sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        tot++;
    endtask

    task automatic stream(input int n, input int gap);
        repeat (n) begin
            send_one();
            idle(gap - 1);
        end
    endtask

    task automatic align();
        while (tot % RAM != 0) begin
            send_one();
            idle(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. reset with buttons toggling, then first sample
        idle(2);
        for (int i = 0; i < 6; i++) begin
            btn_up   = i[0];
            btn_down = ~i[0];
            @(negedge clk);
        end
        check("reset_outputs", outs(), 8'h00);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        send_one();
        check("first_valid", outs(), 8'h30);
        idle(1);

        // 2. three-cycle bounce never reaches the debounced level
        btn_up = 1'b1;
        idle(3);
        btn_up = 1'b0;
        stream(24, 2);
        check("bounce_mode", {6'b0, o_mode}, 8'h00);
        check("bounce_model", {6'b0, m_mode}, 8'h00);

        // 3. deferred commit at frame boundary
        align();
        send_one(); idle(3);
        send_one(); idle(3);
        btn_up = 1'b1;
        for (int s = 2; s < 8; s++) begin
            send_one();
            check("defer_up_hold", {7'b0, o_up}, 8'h00);
            if (s < 7) idle(3);
        end
        @(negedge clk);
        check("defer_commit", outs(), 8'h09);
        idle(2);
        send_one();
        check("defer_fstart", outs(), 8'h39);

        // 4. both held through two boundaries
        btn_down = 1'b1;
        stream(7, 4);
        stream(8, 4);
        check("both_held", outs(), 8'h00);

        // 5. last request within a frame wins
        btn_up   = 1'b0;
        btn_down = 1'b0;
        idle(10);
        align();
        send_one(); idle(7);
        btn_up = 1'b1;
        send_one(); idle(7);
        btn_up = 1'b0;
        stream(3, 8);
        btn_down = 1'b1;
        stream(2, 8);
        send_one();
        check("last_wins_before", {6'b0, o_mode}, 8'h00);
        @(negedge clk);
        check("last_wins", outs(), 8'h06);
        check("last_wins_model", {6'b0, m_mode}, 8'h02);
        btn_down = 1'b0;

        // 6. asynchronous reset mid-frame while in UP
        btn_up = 1'b1;
        stream(8, 4);
        check("mode_up", {6'b0, o_mode}, 8'h01);
        btn_up = 1'b0;
        stream(4, 4);
        send_one();
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        tot = 0;
        idle(3);
        send_one();
        check("post_reset", outs(), 8'h30);
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shifter_ctrl.md
Name: shifter_ctrl

Overview:
- Control front-end for the ping-pong pitch shifter in the hardware test path.
- Synchronises and debounces the two raw pitch pushbuttons and forwards the per-sample valid strobe to the shifter.
- Tracks the shifter's frame position.
- Commits up/down/normal mode changes only at frame boundaries, so a frame never mixes read rates.

Parameters:
- RAM_SIZE, 1024: frame length in samples. Must equal the shifter's RAM_SIZE and be a power of two.
- DEBOUNCE_CYCLES, 50000: clk cycles a synchronised button must hold a new level before it is accepted. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- i_btn_up  input  1  raw pitch-up button, asynchronous, active-high
- i_btn_down  input  1  raw pitch-down button, asynchronous, active-high
- i_sample_valid  input  1  one-cycle strobe per audio sample
- o_valid  output  1  strobe to shifter i_valid
- o_up  output  1  to shifter up
- o_down  output  1  to shifter down
- o_mode  output  2  committed mode: 00 NORMAL, 01 UP, 10 DOWN (11 never driven)
- o_frame_start  output  1  pulse on the first o_valid of each frame

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: all outputs 0. Mode NORMAL, pending mode NORMAL. Frame counter 0. Debounce counters 0. Debounced levels 0. Synchroniser flops 0.
- Synchroniser: 2-flop synchroniser per button. Synchronised level = second flop.
- Debounce, per button:
  - If the synchronised level differs from the debounced level, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level takes the new value and the counter clears.
  - Any cycle where the levels are equal clears the counter.
  - Latency from a clean edge on the pin to the debounced change = 2 + DEBOUNCE_CYCLES cycles.
- Requested mode (from debounced levels): up only -> UP; down only -> DOWN; both or neither -> NORMAL. Matches the shifter's own priority.
- Pending mode register: updated every cycle from the requested mode. Multiple changes within one frame: the last value wins.
- o_valid: i_sample_valid registered once (1-cycle latency), no gaps or drops. Back-to-back input strobes give back-to-back output strobes.
- Frame counter:
  - Width $clog2(RAM_SIZE). Increments on every cycle with o_valid=1.
  - Wraps RAM_SIZE-1 -> 0, aligned with the shifter's write address and bank swap.
- Frame boundary: o_valid=1 and frame counter == RAM_SIZE-1.
- Mode FSM (NORMAL, UP, DOWN):
  - Transitions occur only on a frame-boundary cycle; next state = pending mode.
  - Any state can reach any state. Pending == current is a self-loop.
  - o_up, o_down and o_mode are registered decodes of the FSM state. They change on the cycle after the boundary o_valid, so the first sample of the new frame sees the new mode.
- o_frame_start = o_valid and frame counter == 0, combinational from registers. Asserted with the very first o_valid after reset.
- Boundary coincident with a debounce commit on the same cycle: the pending value used is the pre-update one. The new request applies at the next boundary.
- i_sample_valid absent: counter, FSM and outputs hold indefinitely. Debounce keeps running.
- Reset mid-frame: all state returns to reset values immediately (asynchronously). The next o_valid is frame position 0.

Optional Feature:
- Macro: SHIFTER_CTRL_LATCH_EN.
- Defined (latching mode):
  - A debounced rising edge on up toggles the requested mode between UP and NORMAL.
  - A debounced rising edge on down toggles it between DOWN and NORMAL.
  - Rising edges on both in the same cycle leave the request unchanged.
  - The request holds with buttons released.
  - Requests still commit only at frame boundaries.
- Undefined: momentary levels as in Behaviour. The latch register and edge detect are not built.

Test Plan (RAM_SIZE=8, DEBOUNCE_CYCLES=4):
1. Reset: hold rst_n=0 with buttons toggling -> all outputs 0. Release, then one i_sample_valid -> o_valid=1 and o_frame_start=1 one cycle later, o_mode=00.
2. Bounce: i_btn_up high for 3 cycles then low, samples streaming -> o_mode stays 00 across 3 frames.
3. Deferred commit: i_btn_up held high from sample 2 of a frame -> o_up stays 0 through the 8th o_valid, becomes 1 on the next cycle with o_mode=01, and o_frame_start pulses on the following o_valid.
4. Both held: up and down held high through 2 boundaries -> o_up=0, o_down=0, o_mode=00.
5. Last wins: up accepted at sample 1, released, down accepted at sample 5 of the same frame -> at the boundary o_down=1, o_up=0, o_mode=10.
6. Async reset mid-frame: rst_n pulsed low at sample 4 in mode UP -> outputs 0 immediately. The next o_valid has o_frame_start=1 and the mode is NORMAL.
